fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
Sequencer for the 128-point xfft_0 core in the spectrum-analysis path. Captures one frame of ADC samples into an internal buffer and sends the FFT config word over the config channel. Streams the frame into the FFT data channel with correct AXI-Stream valid/ready/last handling, then tracks the output frame and reports completion and errors. Replaces bench-style hand driving of the core in the real design.

Parameters:
N_PTS, 128, frame length in samples; power of two, 8..1024
DATA_W, 16, real sample width; imaginary part is driven as zero
CFG_WORD, 8'h01, value driven on cfg_tdata (bit0 = 1 selects forward FFT)
TIMEOUT, 4096, maximum clk cycles allowed in SEND or WAIT_OUT before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms one frame; ignored unless busy=0
adc_data  in  DATA_W  signed sample
adc_valid  in  1  sample strobe, at most one per cycle
cfg_tdata  out  8  FFT config word
cfg_tvalid  out  1  config valid
cfg_tready  in  1  config ready from core
s_tdata  out  2*DATA_W  {imag=0, real=sample} to core
s_tvalid  out  1  data valid to core
s_tready  in  1  core ready
s_tlast  out  1  last sample of frame
m_tvalid  in  1  core output valid
m_tlast  in  1  core output last
m_tready  out  1  output ready to core
bin_idx  out  log2(N_PTS)  index of the current output bin, valid with m_tvalid
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when the output frame completes cleanly
err  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, buffer contents don't-care. m_tready is 0 in reset and 1 afterwards, constant.
- States: IDLE -> CFG -> FILL -> SEND -> WAIT_OUT -> IDLE.
- IDLE: when start=1, clear err and the counters, then go to CFG.
- CFG: cfg_tvalid=1, cfg_tdata=CFG_WORD. Hold both until the cycle where cfg_tvalid and cfg_tready are both 1. After that handshake, drop cfg_tvalid on the next cycle and go to FILL. CFG is sent on every frame.
- FILL: on each adc_valid, write buf[wr_addr] = adc_data and increment wr_addr. After the write at wr_addr = N_PTS-1, go to SEND with rd_addr=0. adc_valid outside FILL is ignored.
- SEND: s_tvalid=1, s_tdata={DATA_W'0, buf[rd_addr]}, s_tlast=(rd_addr==N_PTS-1).
  - A beat is accepted when s_tvalid and s_tready are both 1. rd_addr increments only on an accepted beat.
  - While s_tready=0, s_tdata and s_tlast stay stable; s_tvalid is never deasserted mid-frame.
  - When the last beat is accepted, deassert s_tvalid and s_tlast on the next cycle and go to WAIT_OUT.
- WAIT_OUT: each m_tvalid beat increments out_cnt. bin_idx = out_cnt, combinational, valid in the same cycle as m_tvalid.
  - On m_tvalid with m_tlast: if out_cnt == N_PTS-1, pulse frame_done; otherwise set err and do not pulse frame_done. Go to IDLE either way.
  - A beat with out_cnt == N_PTS-1 and m_tlast=0 sets err and stays in WAIT_OUT.
  - out_cnt wraps modulo N_PTS.
- Watchdog: a cycle counter is reset on entry to SEND and to WAIT_OUT. When it reaches TIMEOUT, set err, deassert s_tvalid and s_tlast, and go to IDLE. FILL has no timeout.
- Simultaneous events:
  - start while busy=1 is ignored.
  - start in the same cycle as a frame_done pulse is ignored; the frame_done cycle counts as busy.
- Async reset mid-operation: return to IDLE immediately and drop every valid. The core must be reset by the same rst_n.
- busy = (state != IDLE).

Optional Feature:
FFT_FRAME_AUTO_EN
- Defined: after a clean frame_done, go directly to CFG without waiting for start. This gives continuous back-to-back frames.
  - An error still returns to IDLE and waits for start.
  - The first frame after reset still needs start.
- Undefined: single-shot only, as described in Behaviour.

Test Plan:
- Config and fill: reset, start pulse, cfg_tready held 0 for 5 cycles then 1 -> cfg_tvalid=1 with cfg_tdata=8'h01 for exactly 6 cycles; then 128 adc_valid samples of ramp 0..127 -> state SEND.
- Full-rate stream: s_tready=1 -> 128 consecutive beats, s_tdata[15:0]=0..127, upper half 0, s_tlast only on beat 127, s_tvalid low on the next cycle.
- Backpressure: s_tready toggles 1,0,0,1 pseudo-randomly -> no sample lost or duplicated; s_tdata stable while s_tready=0; exactly 128 accepted beats.
- Output tracking: core model returns 128 m_tvalid beats with m_tlast on the last -> bin_idx counts 0..127, frame_done pulses 1 cycle, busy falls the same cycle, err=0.
- Error and timeout: m_tlast on beat 100 -> err=1 and no frame_done. Separately, s_tready held 0 -> err=1 after 4096 cycles, s_tvalid=0, busy=0. A following start clears err.
- Reset and auto mode: assert rst_n low mid-SEND -> all outputs 0 asynchronously. With FFT_FRAME_AUTO_EN defined, one start gives 3 consecutive frame_done pulses with no further start.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequencer for the xfft_0 core (config, capture, stream, output tracking).
// Optional macro FFT_FRAME_AUTO_EN: restart the next frame automatically after a clean one.
module fft_frame_ctrl #(
    parameter int         N_PTS    = 128,
    parameter int         DATA_W   = 16,
    parameter logic [7:0] CFG_WORD = 8'h01,
    parameter int         TIMEOUT  = 4096,
    localparam int        AW       = $clog2(N_PTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    output logic [7:0]          cfg_tdata,
    output logic                cfg_tvalid,
    input  logic                cfg_tready,
    output logic [2*DATA_W-1:0] s_tdata,
    output logic                s_tvalid,
    input  logic                s_tready,
    output logic                s_tlast,
    input  logic                m_tvalid,
    input  logic                m_tlast,
    output logic                m_tready,
    output logic [AW-1:0]       bin_idx,
    output logic                busy,
    output logic                frame_done,
    output logic                err
);

    localparam int              WDW    = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0]   LAST   = AW'(N_PTS - 1);
    localparam logic [WDW-1:0]  WD_LIM = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_FILL,
        S_SEND,
        S_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [AW-1:0]     out_q, out_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              rdy_q;
    logic [DATA_W-1:0] mem [N_PTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            out_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            out_q   <= out_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            done_q  <= done_d;
            rdy_q   <= 1'b1;
        end
    end

    // Sample buffer has no reset; contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && adc_valid)
            mem[wr_q] <= adc_data;
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        out_d   = out_q;
        wd_d    = wd_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // The frame_done cycle still blocks a new start.
                if (start && !done_q) begin
                    err_d   = 1'b0;
                    wr_d    = '0;
                    rd_d    = '0;
                    out_d   = '0;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                if (cfg_tready)
                    state_d = S_FILL;
            end
            S_FILL: begin
                if (adc_valid) begin
                    wr_d = wr_q + 1'b1;
                    if (wr_q == LAST) begin
                        rd_d    = '0;
                        wd_d    = '0;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                wd_d = wd_q + 1'b1;
                if (wd_q == WD_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (s_tready) begin
                    rd_d = rd_q + 1'b1;
                    if (rd_q == LAST) begin
                        wd_d    = '0;
                        out_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (wd_q == WD_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (m_tvalid) begin
                    out_d = out_q + 1'b1;
                    if (m_tlast) begin
                        state_d = S_IDLE;
                        if (out_q == LAST) begin
                            done_d = 1'b1;
`ifdef FFT_FRAME_AUTO_EN
                            wr_d    = '0;
                            rd_d    = '0;
                            out_d   = '0;
                            state_d = S_CFG;
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (out_q == LAST) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign cfg_tvalid = (state_q == S_CFG);
    assign cfg_tdata  = cfg_tvalid ? CFG_WORD : 8'h00;
    assign s_tvalid   = (state_q == S_SEND);
    assign s_tlast    = s_tvalid && (rd_q == LAST);
    assign s_tdata    = s_tvalid ? {{DATA_W{1'b0}}, mem[rd_q]} : '0;
    assign m_tready   = rdy_q;
    assign bin_idx    = out_q;
    assign frame_done = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: randomized bench against a frame-level reference model.
// Define FFT_FRAME_AUTO_EN for both bench and RTL to run the back-to-back frame case.
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

    localparam int N   = 128;
    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [7:0]  cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready = 1'b0;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready = 1'b0;
    logic        s_tlast;
    logic        m_tvalid = 1'b0;
    logic        m_tlast = 1'b0;
    logic        m_tready;
    logic [6:0]  bin_idx;
    logic        busy;
    logic        frame_done;
    logic        err;

    fft_frame_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .bin_idx    (bin_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 config, 2 capture, 3 stream, 4 output.
    int          ph;
    logic [15:0] smp[$];
    int          n_sent;
    int          n_out;
    int          t_in;
    bit          f_err;
    bit          f_done;
    bit          f_rdy;

    task automatic model_reset();
        ph = 0;
        smp.delete();
        n_sent = 0;
        n_out = 0;
        t_in = 0;
        f_err = 0;
        f_done = 0;
        f_rdy = 0;
    endtask

    task automatic model_step();
        bit done_now;
        done_now = 0;
        f_rdy = 1;
        case (ph)
            0: if (start && !f_done) begin
                f_err = 0;
                smp.delete();
                n_sent = 0;
                n_out = 0;
                ph = 1;
            end
            1: if (cfg_tready) ph = 2;
            2: if (adc_valid) begin
                smp.push_back(adc_data);
                if (smp.size() == N) begin
                    ph = 3;
                    t_in = 0;
                end
            end
            3: begin
                t_in++;
                if (t_in == TMO) begin
                    f_err = 1;
                    ph = 0;
                end else if (s_tready) begin
                    n_sent++;
                    if (n_sent == N) begin
                        ph = 4;
                        t_in = 0;
                        n_out = 0;
                    end
                end
            end
            4: begin
                t_in++;
                if (t_in == TMO) begin
                    f_err = 1;
                    ph = 0;
                end else if (m_tvalid) begin
                    if (m_tlast) begin
                        if (n_out % N == N - 1) begin
                            done_now = 1;
                            ph = 0;
`ifdef FFT_FRAME_AUTO_EN
                            ph = 1;
                            smp.delete();
                            n_sent = 0;
`endif
                        end else begin
                            f_err = 1;
                            ph = 0;
                        end
                    end else if (n_out % N == N - 1) begin
                        f_err = 1;
                    end
                    n_out++;
                end
            end
            default: ph = 0;
        endcase
        f_done = done_now;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    int          cfg_cyc = 0;
    int          done_cnt = 0;
    logic [31:0] beats[$];
    bit          lasts[$];

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'(ph != 0));
            chk("cfg_tvalid", 64'(cfg_tvalid), 64'(ph == 1));
            chk("cfg_tdata", 64'(cfg_tdata), 64'(ph == 1 ? 8'h01 : 8'h00));
            chk("s_tvalid", 64'(s_tvalid), 64'(ph == 3));
            chk("s_tlast", 64'(s_tlast), 64'(ph == 3 && n_sent == N - 1));
            chk("s_tdata", 64'(s_tdata), 64'(ph == 3 ? {16'h0, smp[n_sent]} : 32'h0));
            chk("bin_idx", 64'(bin_idx), 64'(n_out % N));
            chk("frame_done", 64'(frame_done), 64'(f_done));
            chk("err", 64'(err), 64'(f_err));
            chk("m_tready", 64'(m_tready), 64'(f_rdy));
            if (cfg_tvalid) cfg_cyc++;
            if (frame_done) done_cnt++;
            if (s_tvalid && s_tready) begin
                beats.push_back(s_tdata);
                lasts.push_back(s_tlast);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_cfg(input int hold);
        cfg_tready = 1'b0;
        repeat (hold) begin
            adc_valid = 1'($urandom_range(0, 1));
            adc_data = 16'($urandom);
            tick();
        end
        adc_valid = 1'b0;
        cfg_tready = 1'b1;
        tick();
        cfg_tready = 1'b0;
    endtask

    task automatic fill(input bit ramp, input bit noisy_start);
        for (int i = 0; i < N; i++) begin
            adc_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                adc_data = 16'($urandom);
                start = noisy_start && ($urandom_range(0, 7) == 0);
                tick();
            end
            start = 1'b0;
            adc_data = ramp ? 16'(i) : 16'($urandom);
            adc_valid = 1'b1;
            tick();
        end
        adc_valid = 1'b0;
    endtask

    task automatic send(input bit rnd);
        int k;
        k = 0;
        beats.delete();
        lasts.delete();
        while (beats.size() < N && k < 3000) begin
            s_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        s_tready = 1'b0;
        chk("send_beats", 64'(beats.size()), 64'(N));
    endtask

    task automatic core_out(input int n, input int last_at, input bit pin);
        for (int i = 0; i < n; i++) begin
            m_tvalid = 1'b0;
            m_tlast = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            m_tvalid = 1'b1;
            m_tlast = (i == last_at);
            if (pin) begin
                @(negedge clk);
                chk("bin_seq", 64'(bin_idx), 64'(i));
            end
            tick();
        end
        m_tvalid = 1'b0;
        m_tlast = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_tready", 64'(m_tready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("m_tready_up", 64'(m_tready), 64'd1);
        tick();
`ifdef FFT_FRAME_AUTO_EN
        done_cnt = 0;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            do_cfg($urandom_range(0, 3));
            fill(1'b0, 1'b0);
            send(1'b1);
            core_out(N, N - 1, 1'b0);
        end
        tick();
        chk("auto_done_cnt", 64'(done_cnt), 64'd3);
        chk("auto_err", 64'(err), 64'd0);
`else
        // Frame 1: config hold, ramp capture, full-rate stream.
        cfg_cyc = 0;
        done_cnt = 0;
        pulse_start();
        do_cfg(5);
        chk("cfg_cycles", 64'(cfg_cyc), 64'd6);
        fill(1'b1, 1'b0);
        send(1'b0);
        for (int i = 0; i < beats.size(); i++) begin
            chk("beat_data", 64'(beats[i]), 64'(i));
            chk("beat_last", 64'(lasts[i]), 64'(i == N - 1));
        end
        @(negedge clk);
        chk("s_tvalid_after", 64'(s_tvalid), 64'd0);
        core_out(N, N - 1, 1'b1);
        start = 1'b1;
        @(negedge clk);
        chk("done_pulse", 64'(frame_done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_on_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(frame_done), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd1);
        tick();

        // Frame 2: random data, backpressure, stray starts while busy.
        pulse_start();
        do_cfg($urandom_range(0, 3));
        fill(1'b0, 1'b1);
        send(1'b1);
        core_out(N, N - 1, 1'b0);
        tick();
        chk("done_count2", 64'(done_cnt), 64'd2);

        // Frame 3: early m_tlast on beat 100.
        pulse_start();
        do_cfg(1);
        fill(1'b0, 1'b0);
        send(1'b1);
        core_out(101, 100, 1'b0);
        @(negedge clk);
        chk("early_last_err", 64'(err), 64'd1);
        chk("early_last_busy", 64'(busy), 64'd0);
        tick();
        chk("early_last_nodone", 64'(done_cnt), 64'd2);

        // Frame 4: stream stalls forever until the watchdog fires.
        pulse_start();
        @(negedge clk);
        chk("start_clears_err", 64'(err), 64'd0);
        tick();
        do_cfg(0);
        fill(1'b0, 1'b0);
        s_tready = 1'b0;
        c = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (s_tvalid) c++;
            else if (c > 0) break;
        end
        chk("timeout_cycles", 64'(c), 64'(TMO));
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("timeout_s_tvalid", 64'(s_tvalid), 64'd0);
        tick();

        // Frame 5: asynchronous reset in the middle of streaming.
        pulse_start();
        @(negedge clk);
        chk("start_clears_err2", 64'(err), 64'd0);
        tick();
        do_cfg(2);
        fill(1'b0, 1'b0);
        repeat (40) begin
            s_tready = 1'($urandom_range(0, 1));
            tick();
        end
        s_tready = 1'b0;
        #3;
        rst_n = 1'b0;
        #0.5;
        chk("arst_s_tvalid", 64'(s_tvalid), 64'd0);
        chk("arst_s_tlast", 64'(s_tlast), 64'd0);
        chk("arst_s_tdata", 64'(s_tdata), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cfg_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("arst_m_tready", 64'(m_tready), 64'd0);
        chk("arst_bin_idx", 64'(bin_idx), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Frame 6: clean randomized frame after reset.
        done_cnt = 0;
        pulse_start();
        do_cfg($urandom_range(0, 4));
        fill(1'b0, 1'b1);
        send(1'b1);
        core_out(N, N - 1, 1'b0);
        tick();
        chk("done_after_reset", 64'(done_cnt), 64'd1);
        chk("err_after_reset", 64'(err), 64'd0);
`endif
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
